// File: rtl/dcache_flush_ctrl.sv
// dcache_flush_ctrl: data-cache miss handler. On a miss in every line it picks
// the line with the highest miss count as victim, optionally writes the old
// line back to memory, then refills it word by word from memory.
// Optional feature macro: DCACHE_WRITEBACK_EN (dirty-victim write-back and
// per-line tag store). Undefined builds a write-through controller.
module dcache_flush_ctrl #(
    parameter int unsigned ADDRBITS      = 32,
    parameter int unsigned DATABITS      = 32,
    parameter int unsigned CACHEADDRBITS = 5,
    parameter int unsigned LSBITS        = 2,
    parameter int unsigned NUMLINES      = 4,
    parameter int unsigned CNTMISSBITS   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ADDRBITS-1:0]             dcache_addr,
    input  logic                            dcache_rdreq,
    input  logic                            dcache_wrreq,
    output logic                            dcache_busy,
    input  logic [NUMLINES-1:0]             line_miss,
    input  logic [NUMLINES-1:0]             line_dirty,
    input  logic [NUMLINES*CNTMISSBITS-1:0] flush_cnt_miss,
    output logic [NUMLINES-1:0]             flush_mode,
    output logic                            flush_write,
    output logic [CACHEADDRBITS-1:0]        flush_addr,
    output logic                            flush_dirty,
    output logic [ADDRBITS-1:0]             mem_addr,
    output logic                            mem_rdreq,
    output logic                            mem_wrreq,
    input  logic                            mem_ack,
    input  logic                            mem_rdvalid,
    output logic [NUMLINES-1:0]             line_out_sel
);

    localparam int unsigned TAGBITS         = ADDRBITS - CACHEADDRBITS - LSBITS;
    localparam int unsigned VICBITS         = (NUMLINES > 1) ? $clog2(NUMLINES) : 1;
    localparam int unsigned UNUSED_DATABITS = DATABITS;
    localparam logic [CACHEADDRBITS-1:0] LAST_IDX = {CACHEADDRBITS{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SELECT    = 3'd1,
        WRITEBACK = 3'd2,
        FILL      = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t                   state;
    logic [CACHEADDRBITS-1:0] idx;
    logic [CACHEADDRBITS-1:0] next_idx;
    logic [VICBITS-1:0]       vic_idx;
    logic [TAGBITS-1:0]       new_tag;
    logic [VICBITS-1:0]       best_idx;
    logic [CNTMISSBITS-1:0]   best_cnt;
    logic                     go_wb;
    logic [TAGBITS-1:0]       wb_tag;
    logic                     unused_bits;

    assign next_idx = idx + CACHEADDRBITS'(1);

    // The fill word sits on line_in only during the rdvalid cycle, so the strobe follows it directly
    assign flush_write = (state == FILL) && mem_rdvalid;

`ifdef DCACHE_WRITEBACK_EN
    logic                wb_req_q;
    logic [NUMLINES-1:0] out_sel_q;
    logic [TAGBITS-1:0]  old_tag [NUMLINES];

    assign go_wb        = |(line_dirty & flush_mode);
    assign wb_tag       = old_tag[vic_idx];
    assign mem_wrreq    = wb_req_q;
    assign line_out_sel = out_sel_q;
    assign unused_bits  = ^dcache_addr[CACHEADDRBITS+LSBITS-1:0];
`else
    assign go_wb        = 1'b0;
    assign wb_tag       = '0;
    assign mem_wrreq    = 1'b0;
    assign line_out_sel = '0;
    assign unused_bits  = ^{dcache_addr[CACHEADDRBITS+LSBITS-1:0], line_dirty};
`endif

    // Victim choice: largest miss count, strict compare keeps the lowest index on ties
    always_comb begin
        best_idx = '0;
        best_cnt = flush_cnt_miss[0 +: CNTMISSBITS];
        for (int i = 1; i < NUMLINES; i++) begin
            if (flush_cnt_miss[i*CNTMISSBITS +: CNTMISSBITS] > best_cnt) begin
                best_cnt = flush_cnt_miss[i*CNTMISSBITS +: CNTMISSBITS];
                best_idx = VICBITS'(i);
            end
        end
    end

    // Flush FSM with registered memory/cache-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            vic_idx     <= '0;
            new_tag     <= '0;
            flush_mode  <= '0;
            flush_addr  <= '0;
            flush_dirty <= 1'b0;
            mem_addr    <= '0;
            mem_rdreq   <= 1'b0;
            dcache_busy <= 1'b0;
`ifdef DCACHE_WRITEBACK_EN
            wb_req_q    <= 1'b0;
            out_sel_q   <= '0;
            for (int i = 0; i < NUMLINES; i++) begin
                old_tag[i] <= '0;
            end
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((dcache_rdreq || dcache_wrreq) && (&line_miss)) begin
                        state       <= SELECT;
                        dcache_busy <= 1'b1;
                        vic_idx     <= best_idx;
                        flush_mode  <= NUMLINES'(1) << best_idx;
                        flush_dirty <= dcache_wrreq;
                        new_tag     <= dcache_addr[ADDRBITS-1 -: TAGBITS];
                    end
                end
                SELECT: begin
                    idx        <= '0;
                    flush_addr <= '0;
                    if (go_wb) begin
                        state    <= WRITEBACK;
                        mem_addr <= {wb_tag, {CACHEADDRBITS{1'b0}}, {LSBITS{1'b0}}};
`ifdef DCACHE_WRITEBACK_EN
                        wb_req_q  <= 1'b1;
                        out_sel_q <= flush_mode;
`endif
                    end else begin
                        state     <= FILL;
                        mem_rdreq <= 1'b1;
                        mem_addr  <= {new_tag, {CACHEADDRBITS{1'b0}}, {LSBITS{1'b0}}};
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        if (idx == LAST_IDX) begin
                            state     <= FILL;
                            idx       <= '0;
                            mem_rdreq <= 1'b1;
                            mem_addr  <= {new_tag, {CACHEADDRBITS{1'b0}}, {LSBITS{1'b0}}};
`ifdef DCACHE_WRITEBACK_EN
                            wb_req_q  <= 1'b0;
                            out_sel_q <= '0;
`endif
                        end else begin
                            idx      <= next_idx;
                            mem_addr <= {wb_tag, next_idx, {LSBITS{1'b0}}};
                        end
                    end
                end
                FILL: begin
                    // Request side and data side advance independently
                    if (mem_rdreq && mem_ack) begin
                        if (idx == LAST_IDX) begin
                            mem_rdreq <= 1'b0;
                        end else begin
                            idx      <= next_idx;
                            mem_addr <= {new_tag, next_idx, {LSBITS{1'b0}}};
                        end
                    end
                    if (mem_rdvalid) begin
                        if (flush_addr == LAST_IDX) begin
                            state <= DONE;
`ifdef DCACHE_WRITEBACK_EN
                            old_tag[vic_idx] <= new_tag;
`endif
                        end else begin
                            flush_addr <= flush_addr + CACHEADDRBITS'(1);
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    dcache_busy <= 1'b0;
                    flush_mode  <= '0;
                    flush_dirty <= 1'b0;
                    flush_addr  <= '0;
                    idx         <= '0;
                    mem_rdreq   <= 1'b0;
                    mem_addr    <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
